// File: rtl/pi_channel_scheduler.sv
// pi_channel_scheduler: round-robin scheduler that time-shares one PI compute core among
// NUM_CH control channels. Each channel raises a one-cycle request, is granted in turn,
// and gets a one-cycle ack once the core reports completion.
// Optional core_done watchdog: define PI_SCHED_TIMEOUT_EN to enable it.
module pi_channel_scheduler #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic                      sched_en,
  input  logic [NUM_CH-1:0]         ch_req,
  output logic                      core_start,
  output logic [$clog2(NUM_CH)-1:0] core_ch_sel,
  input  logic                      core_done,
  output logic [NUM_CH-1:0]         ch_ack,
  output logic                      busy,
  output logic [NUM_CH-1:0]         overrun,
  output logic                      timeout_err,
  input  logic                      err_clr
);

  localparam int unsigned CW = $clog2(NUM_CH);

  // An illegal parameter combination stops elaboration.
  if (NUM_CH < 2 || NUM_CH > 8 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_cfg
    $error("pi_channel_scheduler: NUM_CH or TIMEOUT_CYC out of range");
  end

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StRetire} state_e;

  state_e            state_q, state_d;
  logic [NUM_CH-1:0] pending_q, pending_d;
  logic [NUM_CH-1:0] overrun_q, overrun_d;
  logic [NUM_CH-1:0] grant_clr;
  logic [CW-1:0]     sel_q, sel_d;
  logic [CW-1:0]     last_q, last_d;
  logic [CW-1:0]     rr_pick;
  logic [CW-1:0]     rr_idx;

`ifdef PI_SCHED_TIMEOUT_EN
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        timeout_q, timeout_d;
  logic        timeout_set;
  logic        timeout_hit;

  // Counter holds the number of WAIT cycles already completed.
  assign timeout_hit = (wait_cnt_q == 16'(TIMEOUT_CYC - 1));
`endif

  // Round-robin pick: scan downward so the channel closest after last_q is assigned last.
  always_comb begin
    rr_pick = last_q;
    rr_idx  = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      rr_idx = CW'((int'(last_q) + k) % NUM_CH);
      if (pending_q[rr_idx]) begin
        rr_pick = rr_idx;
      end
    end
  end

  // FSM next state and per-state outputs.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    last_d     = last_q;
    grant_clr  = '0;
    core_start = 1'b0;
    ch_ack     = '0;
`ifdef PI_SCHED_TIMEOUT_EN
    wait_cnt_d  = wait_cnt_q;
    timeout_set = 1'b0;
`endif
    case (state_q)
      StIdle: begin
        if (sched_en && (|pending_q)) begin
          sel_d   = rr_pick;
          state_d = StIssue;
        end
      end
      StIssue: begin
        core_start         = 1'b1;
        grant_clr[sel_q]   = 1'b1;
`ifdef PI_SCHED_TIMEOUT_EN
        wait_cnt_d         = '0;
`endif
        state_d            = StWait;
      end
      StWait: begin
        if (core_done) begin
          state_d = StRetire;
`ifdef PI_SCHED_TIMEOUT_EN
        end else if (timeout_hit) begin
          // Give up on this update: no ack, but the channel still loses priority.
          timeout_set = 1'b1;
          last_d      = sel_q;
          state_d     = StIdle;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
`endif
        end
      end
      StRetire: begin
        ch_ack[sel_q] = 1'b1;
        last_d        = sel_q;
        state_d       = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Pending and overrun bookkeeping; a request in the grant cycle re-arms pending cleanly.
  always_comb begin
    pending_d = (pending_q & ~grant_clr) | ch_req;
    overrun_d = (overrun_q & ~{NUM_CH{err_clr}}) | (ch_req & pending_q & ~grant_clr);
`ifdef PI_SCHED_TIMEOUT_EN
    timeout_d = (timeout_q & ~err_clr) | timeout_set;
`endif
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q   <= StIdle;
      pending_q <= '0;
      overrun_q <= '0;
      sel_q     <= '0;
      last_q    <= CW'(NUM_CH - 1);
`ifdef PI_SCHED_TIMEOUT_EN
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
`ifdef PI_SCHED_TIMEOUT_EN
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  assign busy        = (state_q != StIdle);
  assign core_ch_sel = sel_q;
  assign overrun     = overrun_q;
`ifdef PI_SCHED_TIMEOUT_EN
  assign timeout_err = timeout_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_pi_channel_scheduler.sv
// Self-checking bench for pi_channel_scheduler (NUM_CH=4, TIMEOUT_CYC=10).
module tb_pi_channel_scheduler;

  localparam int unsigned NCH = 4;
  localparam int          TO  = 10;

  logic       ACLK = 1'b0;
  logic       ARESET = 1'b1;
  logic       sched_en = 1'b0;
  logic [3:0] ch_req = '0;
  logic       core_done = 1'b0;
  logic       err_clr = 1'b0;
  logic       core_start;
  logic [1:0] core_ch_sel;
  logic [3:0] ch_ack;
  logic       busy;
  logic [3:0] overrun;
  logic       timeout_err;

  pi_channel_scheduler #(
    .NUM_CH      (NCH),
    .TIMEOUT_CYC (TO)
  ) dut (
    .ACLK        (ACLK),
    .ARESET      (ARESET),
    .sched_en    (sched_en),
    .ch_req      (ch_req),
    .core_start  (core_start),
    .core_ch_sel (core_ch_sel),
    .core_done   (core_done),
    .ch_ack      (ch_ack),
    .busy        (busy),
    .overrun     (overrun),
    .timeout_err (timeout_err),
    .err_clr     (err_clr)
  );

  always #5 ACLK = ~ACLK;

  int errors = 0;
  int checks = 0;

  // Reference model: pending set, and the in-flight update described by the cycle numbers
  // of its start pulse and of its ack pulse.
  logic [3:0] m_pend, m_ovr;
  logic       m_to, m_inf;
  int         m_last, m_sel, m_start, m_ack, m_cyc;

  // Outputs sampled at the falling edge of the most recent cycle.
  logic       s_start, s_busy;
  logic [1:0] s_sel;
  logic [3:0] s_ack, s_ovr;

  typedef struct {
    logic [3:0] req;
    logic       en;
    logic       done;
    logic       clr;
    logic       e_start;
    logic [1:0] e_sel;
    logic [3:0] e_ack;
    logic       e_busy;
    logic [3:0] e_ovr;
  } vec_t;

  vec_t vecs[26];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend  = '0;
    m_ovr   = '0;
    m_to    = 1'b0;
    m_inf   = 1'b0;
    m_last  = NCH - 1;
    m_sel   = 0;
    m_start = -10;
    m_ack   = -1;
    m_cyc   = 0;
  endtask

  task automatic model_check();
    logic [3:0] e_ack;
    e_ack = '0;
    if (m_inf && m_ack == m_cyc) e_ack[m_sel] = 1'b1;
    chk("busy", 32'(busy), 32'(m_inf));
    chk("core_start", 32'(core_start), 32'(m_inf && m_cyc == m_start));
    chk("core_ch_sel", 32'(core_ch_sel), 32'(m_sel));
    chk("ch_ack", 32'(ch_ack), 32'(e_ack));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    chk("timeout_err", 32'(timeout_err), 32'(m_to));
  endtask

  task automatic model_step(input logic [3:0] req, input logic en, input logic done,
                            input logic clr);
    logic [3:0] gclr, old;
    logic       to_set;
    gclr   = '0;
    to_set = 1'b0;
    old    = m_pend;
    if (m_inf && m_cyc == m_start) gclr[m_sel] = 1'b1;
    m_ovr  = (m_ovr & ~{4{clr}}) | (req & old & ~gclr);
    m_pend = (old & ~gclr) | req;
    if (m_inf) begin
      if (m_ack == m_cyc) begin
        m_inf  = 1'b0;
        m_last = m_sel;
      end else if (m_cyc > m_start && m_ack < 0) begin
        if (done) m_ack = m_cyc + 1;
`ifdef PI_SCHED_TIMEOUT_EN
        else if (m_cyc - m_start == TO) begin
          m_inf  = 1'b0;
          to_set = 1'b1;
          m_last = m_sel;
        end
`endif
      end
    end else if (en && old != 4'b0000) begin
      for (int k = 1; k <= NCH; k++) begin
        if (old[(m_last + k) % NCH]) begin
          m_sel = (m_last + k) % NCH;
          break;
        end
      end
      m_inf   = 1'b1;
      m_start = m_cyc + 1;
      m_ack   = -1;
    end
    m_to = (m_to & ~clr) | to_set;
    m_cyc++;
  endtask

  // One clock cycle: drive at posedge+1, check at negedge, advance model at posedge.
  task automatic cycle(input logic [3:0] req, input logic en, input logic done, input logic clr);
    ch_req    = req;
    sched_en  = en;
    core_done = done;
    err_clr   = clr;
    @(negedge ACLK);
    s_start = core_start;
    s_sel   = core_ch_sel;
    s_ack   = ch_ack;
    s_busy  = busy;
    s_ovr   = overrun;
    model_check();
    @(posedge ACLK);
    model_step(req, en, done, clr);
    #1;
  endtask

  task automatic do_reset();
    ARESET    = 1'b1;
    ch_req    = '0;
    sched_en  = 1'b0;
    core_done = 1'b0;
    err_clr   = 1'b0;
    repeat (2) @(posedge ACLK);
    #1;
    ARESET = 1'b0;
    model_reset();
  endtask

  initial begin
    int n_st, n_ack;
    int ord[4];
    logic dn;

    // Single request, late done, sched_en gating, overrun and err_clr.
    vecs[0]  = '{4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 4'b0000};
    vecs[1]  = '{4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 4'b0000};
    vecs[2]  = '{4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000};
    vecs[3]  = '{4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, 4'b0000};
    vecs[4]  = '{4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, 4'b0000};
    vecs[5]  = '{4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, 4'b0000};
    vecs[6]  = '{4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0001, 1'b1, 4'b0000};
    vecs[7]  = '{4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 4'b0000};
    vecs[8]  = '{4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 4'b0000};
    vecs[9]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 4'b0000};
    vecs[10] = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 4'b0000};
    vecs[11] = '{4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 4'b0000};
    vecs[12] = '{4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 4'b0000, 1'b1, 4'b0000};
    vecs[13] = '{4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 4'b0000, 1'b1, 4'b0000};
    vecs[14] = '{4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 4'b0010, 1'b1, 4'b0000};
    vecs[15] = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 4'b0000, 1'b0, 4'b0000};
    vecs[16] = '{4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 4'b0000, 1'b0, 4'b0000};
    vecs[17] = '{4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 4'b0000, 1'b0, 4'b0000};
    vecs[18] = '{4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 4'b0000, 1'b0, 4'b0100};
    vecs[19] = '{4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 4'b0000, 1'b0, 4'b0100};
    vecs[20] = '{4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0000, 1'b1, 4'b0100};
    vecs[21] = '{4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 4'b0000, 1'b1, 4'b0100};
    vecs[22] = '{4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 4'b0100, 1'b1, 4'b0100};
    vecs[23] = '{4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 4'b0000, 1'b0, 4'b0100};
    vecs[24] = '{4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 4'b0000, 1'b0, 4'b0000};
    vecs[25] = '{4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 4'b0000, 1'b0, 4'b0000};

    do_reset();
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst core_start", 32'(core_start), 32'd0);
    chk("rst core_ch_sel", 32'(core_ch_sel), 32'd0);
    chk("rst ch_ack", 32'(ch_ack), 32'd0);
    chk("rst overrun", 32'(overrun), 32'd0);
    chk("rst timeout_err", 32'(timeout_err), 32'd0);

    for (int i = 0; i < 26; i++) begin
      cycle(vecs[i].req, vecs[i].en, vecs[i].done, vecs[i].clr);
      chk($sformatf("vec%0d core_start", i), 32'(s_start), 32'(vecs[i].e_start));
      chk($sformatf("vec%0d core_ch_sel", i), 32'(s_sel), 32'(vecs[i].e_sel));
      chk($sformatf("vec%0d ch_ack", i), 32'(s_ack), 32'(vecs[i].e_ack));
      chk($sformatf("vec%0d busy", i), 32'(s_busy), 32'(vecs[i].e_busy));
      chk($sformatf("vec%0d overrun", i), 32'(s_ovr), 32'(vecs[i].e_ovr));
    end

    // All four channels at once, core answers one cycle after each start.
    do_reset();
    n_st  = 0;
    n_ack = 0;
    dn    = 1'b0;
    cycle(4'b1111, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) begin
      cycle(4'b0000, 1'b1, dn, 1'b0);
      dn = s_start;
      if (s_start) begin
        if (n_st < 4) ord[n_st] = int'(s_sel);
        n_st++;
      end
      n_ack += $countones(s_ack);
    end
    chk("rr start count", 32'(n_st), 32'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("rr order[%0d]", i), 32'(ord[i]), 32'(i));
    chk("rr ack count", 32'(n_ack), 32'd4);
    chk("rr busy after", 32'(s_busy), 32'd0);

    // Reset while waiting on the core, then a stray core_done afterwards.
    do_reset();
    cycle(4'b0001, 1'b1, 1'b0, 1'b0);
    repeat (3) cycle(4'b0000, 1'b1, 1'b0, 1'b0);
    chk("pre-reset busy", 32'(s_busy), 32'd1);
    ARESET = 1'b1;
    #1;
    chk("mid-rst busy", 32'(busy), 32'd0);
    chk("mid-rst core_start", 32'(core_start), 32'd0);
    chk("mid-rst core_ch_sel", 32'(core_ch_sel), 32'd0);
    chk("mid-rst ch_ack", 32'(ch_ack), 32'd0);
    @(posedge ACLK);
    #1;
    ARESET = 1'b0;
    model_reset();
    n_ack = 0;
    cycle(4'b0000, 1'b1, 1'b1, 1'b0);
    n_ack += $countones(s_ack);
    repeat (4) begin
      cycle(4'b0000, 1'b1, 1'b0, 1'b0);
      n_ack += $countones(s_ack);
    end
    chk("stray done ack count", 32'(n_ack), 32'd0);
    chk("stray done busy", 32'(s_busy), 32'd0);

`ifdef PI_SCHED_TIMEOUT_EN
    // Core never answers: each grant times out after TO wait cycles without an ack.
    do_reset();
    n_st  = 0;
    n_ack = 0;
    cycle(4'b0011, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) begin
      cycle(4'b0000, 1'b1, 1'b0, 1'b0);
      if (s_start) begin
        if (n_st < 4) ord[n_st] = int'(s_sel);
        n_st++;
      end
      n_ack += $countones(s_ack);
    end
    chk("to start count", 32'(n_st), 32'd2);
    chk("to order[0]", 32'(ord[0]), 32'd0);
    chk("to order[1]", 32'(ord[1]), 32'd1);
    chk("to ack count", 32'(n_ack), 32'd0);
    chk("to timeout_err", 32'(timeout_err), 32'd1);
    cycle(4'b0000, 1'b1, 1'b0, 1'b1);
    cycle(4'b0000, 1'b1, 1'b0, 1'b0);
    chk("to err_clr", 32'(s_ovr) + 32'(timeout_err), 32'd0);
`endif

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      logic [3:0] r;
      for (int b = 0; b < 4; b++) r[b] = ($urandom_range(0, 7) == 0);
      cycle(r, $urandom_range(0, 7) != 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 19) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pi_channel_scheduler.md
PI_CHANNEL_SCHEDULER -- requirements
Module: pi_channel_scheduler

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of PI loop channels sharing one PI compute core (2..8).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 255: maximum ACLK cycles to wait for core_done (1..65535).
REQ-003 SHALL have port ACLK, input, 1: the single clock; all logic is rising-edge.
REQ-004 SHALL have port ARESET, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port sched_en, input, 1: 1 = grants allowed; 0 = no new grants issued.
REQ-006 SHALL have port ch_req, input, NUM_CH: per-channel single-cycle "new sample ready" pulses.
REQ-007 SHALL have port core_start, output, 1: single-cycle start pulse to the PI core.
REQ-008 SHALL have port core_ch_sel, output, clog2(NUM_CH): channel index presented to the PI core; stable from core_start until retire.
REQ-009 SHALL have port core_done, input, 1: single-cycle completion pulse from the PI core.
REQ-010 SHALL have port ch_ack, output, NUM_CH: one-hot single-cycle pulse when that channel's update retires.
REQ-011 SHALL have port busy, output, 1: high in any state other than IDLE.
REQ-012 SHALL have port overrun, output, NUM_CH: sticky per-channel flag for a request arriving while the same channel is already pending.
REQ-013 SHALL have port timeout_err, output, 1: sticky flag for a core_done timeout.
REQ-014 SHALL have port err_clr, input, 1: clears overrun and timeout_err when pulsed.

Function
REQ-015 SHALL latch each ch_req bit into a pending register; the pending bit clears only when that channel is granted.
REQ-016 SHALL set overrun[i] when ch_req[i]=1 and pending[i]=1 in the same cycle; the pending bit stays 1 (no double count).
REQ-017 SHALL treat ch_req[i] arriving in the grant cycle of channel i as a new pending request, not an overrun.
REQ-018 SHALL implement FSM states IDLE, ISSUE, WAIT and RETIRE.
REQ-019 SHALL move IDLE->ISSUE when sched_en=1 and any pending bit (registered) is set.
REQ-020 SHALL select the channel round-robin starting at (last_granted+1) mod NUM_CH; after reset, last_granted = NUM_CH-1, so channel 0 has first priority.
REQ-021 SHALL, in ISSUE, assert core_start for exactly one cycle, drive core_ch_sel, clear the pending bit, and go to WAIT.
REQ-022 SHALL, in WAIT, go to RETIRE on core_done=1; core_done seen in any other state SHALL be ignored.
REQ-023 SHALL, in RETIRE, pulse ch_ack[core_ch_sel] for one cycle, update last_granted, and return to IDLE.
REQ-024 SHALL give a minimum latency from ch_req to core_start of 2 cycles (req latched, IDLE->ISSUE, start).
REQ-025 SHALL NOT abort an in-flight update when sched_en is deasserted; it only blocks IDLE->ISSUE.
REQ-026 SHALL apply err_clr after set when both occur in the same cycle: set wins.

Reset
REQ-027 SHALL, while ARESET=1 (asynchronously), force FSM=IDLE, pending=0, last_granted=NUM_CH-1, core_start=0, core_ch_sel=0, ch_ack=0, busy=0, overrun=0, timeout_err=0, and timeout counter=0.
REQ-028 SHALL abandon an in-flight update on reset mid-operation, with no ch_ack, and SHALL ignore a later stray core_done.

Configuration
REQ-029 SHALL, with macro PI_SCHED_TIMEOUT_EN defined, count cycles in WAIT; at count=TIMEOUT_CYC without core_done it SHALL set timeout_err, skip ch_ack, update last_granted, and return to IDLE.
REQ-030 SHALL, without PI_SCHED_TIMEOUT_EN, omit the counter, wait indefinitely in WAIT, and tie timeout_err to 0.

Verification
REQ-031 SHALL cover: single request, ch_req=0001, core_done 3 cycles after start -> core_start 2 cycles after req, core_ch_sel=0, ch_ack=0001 one cycle after done.
REQ-032 SHALL cover: simultaneous ch_req=1111 with core_done after 1 cycle each -> grant order 0,1,2,3, four ch_ack pulses, busy low afterwards.
REQ-033 SHALL cover: ch_req[2] pulsed twice while channel 2 is pending -> overrun=0100, one update only; err_clr -> overrun=0000.
REQ-034 SHALL cover: PI_SCHED_TIMEOUT_EN defined, TIMEOUT_CYC=10, core_done never asserted -> timeout_err=1 after 10 WAIT cycles, no ch_ack, next pending channel granted.
REQ-035 SHALL cover: ARESET asserted during WAIT, then core_done pulsed after release -> all outputs at reset values, no ch_ack, FSM in IDLE.
REQ-036 SHALL cover: sched_en=0 with ch_req=0010 -> no core_start; sched_en=1 -> core_start 1 cycle later with core_ch_sel=1.
